// File: rtl/ps_line_feeder_pkg.sv
// rtl/ps_line_feeder_pkg.sv - shared video constants, feeder state encoding and marker helper
package ps_line_feeder_pkg;

    localparam int PS_DATA_WIDTH  = 8;
    localparam int PS_LINE_LENGTH = 640;
    localparam int PS_LINE_COUNT  = 480;
    localparam int PS_REQ_GAP     = 2;

    // Encodings are shared with the kernel line-buffer stage; keep values fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } feed_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } line_marks_t;

    function automatic line_marks_t calc_marks(
        input logic first_pix,
        input logic last_pix,
        input logic first_line,
        input logic last_line
    );
        line_marks_t m;
        m.sof = first_pix & first_line;
        m.eol = last_pix;
        m.eof = last_pix & last_line;
        return m;
    endfunction

endpackage

// File: rtl/ps_line_feeder.sv
// rtl/ps_line_feeder.sv - drains one image line from the pixel FIFO per level request
module ps_line_feeder
    import ps_line_feeder_pkg::*;
#(
    parameter int LINE_LENGTH = PS_LINE_LENGTH,
    parameter int LINE_COUNT  = PS_LINE_COUNT,
    parameter int DATA_WIDTH  = PS_DATA_WIDTH,
    parameter int REQ_GAP     = PS_REQ_GAP
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                  o_fifo_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic                  o_busy,
    input  logic                  i_clr_status,
    output logic                  o_starved
);

    localparam int PW = $clog2(LINE_LENGTH) + 1;
    localparam int LW = $clog2(LINE_COUNT) + 1;
    localparam int GW = $clog2(REQ_GAP + 1) + 1;

    localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_LENGTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_COUNT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((REQ_GAP > 0) ? (REQ_GAP - 1) : 0);

    feed_state_e           state_q, state_d;
    logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]         line_cnt_q, line_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  starved_q, starved_d;
    logic                  rd;
    line_marks_t           marks_rd;

    logic                  rd_d1_q;
    line_marks_t           marks_d1_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    line_marks_t           marks_out_q;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rd         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // Requests are not looked at here: a started line always completes.
                rd = ~i_fifo_empty;
                if (rd) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d  = '0;
                        line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + 1'b1;
                        gap_cnt_d  = '0;
                        state_d    = (REQ_GAP == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        starved_d = i_clr_status ? 1'b0
                  : (starved_q | ((state_q == ST_BURST) & i_fifo_empty));

        // A reset cycle must not pop a pixel the discarded pipeline would then lose twice.
        o_fifo_rd = rd & i_rstn;

        marks_rd = calc_marks(pix_cnt_q == '0, pix_cnt_q == PIX_LAST,
                              line_cnt_q == '0, line_cnt_q == LINE_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            gap_cnt_q  <= '0;
            starved_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            starved_q  <= starved_d;
        end
    end

    // FIFO data lands one cycle after the strobe; markers travel alongside it.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_d1_q     <= 1'b0;
            marks_d1_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            marks_out_q <= '0;
        end else begin
            rd_d1_q    <= o_fifo_rd;
            marks_d1_q <= marks_rd;
            if (rd_d1_q) begin
                data_q      <= i_fifo_rdata;
                valid_q     <= 1'b1;
                marks_out_q <= marks_d1_q;
            end else begin
                valid_q     <= 1'b0;
                marks_out_q <= '0;
            end
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_sof     = marks_out_q.sof;
    assign o_eol     = marks_out_q.eol;
    assign o_eof     = marks_out_q.eof;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_starved = starved_q;

endmodule

// File: tb/tb_ps_line_feeder.sv
// tb/tb_ps_line_feeder.sv - self-checking bench for ps_line_feeder
module tb_ps_line_feeder;

    localparam int LL    = 8;
    localparam int LC    = 4;
    localparam int RG    = 2;
    localparam int DW    = 8;
    localparam int MEMSZ = 2048;

    logic          i_clk;
    logic          i_rstn;
    logic          i_req;
    logic          i_fifo_empty;
    logic [DW-1:0] i_fifo_rdata;
    logic          o_fifo_rd;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;
    logic          o_busy;
    logic          i_clr_status;
    logic          o_starved;

    ps_line_feeder #(
        .LINE_LENGTH(LL),
        .LINE_COUNT (LC),
        .DATA_WIDTH (DW),
        .REQ_GAP    (RG)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (i_req),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_rdata(i_fifo_rdata),
        .o_fifo_rd   (o_fifo_rd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_sof       (o_sof),
        .o_eol       (o_eol),
        .o_eof       (o_eof),
        .o_busy      (o_busy),
        .i_clr_status(i_clr_status),
        .o_starved   (o_starved)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [DW-1:0] mem [MEMSZ];
    int            rd_ptr = 0;

    always @(posedge i_clk) begin
        if (o_fifo_rd) begin
            i_fifo_rdata <= mem[rd_ptr % MEMSZ];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int vectors    = 0;
    int miscompares = 0;
    int mon_n      = 0;
    int exp_ptr    = 0;
    int sof_cnt    = 0;
    int eof_cnt    = 0;
    bit mon_en     = 1'b0;

    typedef struct packed {
        logic          req;
        logic          empty;
        logic          clr;
        logic          rd;
        logic          valid;
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          busy;
        logic          starved;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic rq, input logic em, input logic cl,
                                input logic rd, input logic vl, input logic [DW-1:0] d,
                                input logic so, input logic eo, input logic ef,
                                input logic bs, input logic st);
        vec_t v;
        v = '{req:rq, empty:em, clr:cl, rd:rd, valid:vl, data:d,
              sof:so, eol:eo, eof:ef, busy:bs, starved:st};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    // Reference stream: the n-th pixel since reset is pix n%LL of line (n/LL)%LC,
    // carrying the FIFO word that follows the ones already consumed.
    task automatic sample();
        int   pix;
        int   line;
        logic es;
        logic el;
        logic ef;
        @(negedge i_clk);
        if (!i_rstn) begin
            mon_n   = 0;
            exp_ptr = rd_ptr;
            sof_cnt = 0;
            eof_cnt = 0;
        end else if (o_valid) begin
            pix  = mon_n % LL;
            line = (mon_n / LL) % LC;
            es   = (pix == 0) && (line == 0);
            el   = (pix == LL - 1);
            ef   = el && (line == LC - 1);
            if (mon_en) begin
                check($sformatf("stream pixel %0d", mon_n),
                      64'({o_data, o_sof, o_eol, o_eof}),
                      64'({mem[exp_ptr % MEMSZ], es, el, ef}));
            end
            sof_cnt += int'(o_sof);
            eof_cnt += int'(o_eof);
            mon_n++;
            exp_ptr++;
        end
    endtask

    task automatic do_reset(input string name);
        adv();
        i_rstn       = 1'b0;
        i_req        = 1'b0;
        i_fifo_empty = 1'b0;
        i_clr_status = 1'b0;
        sample();
        adv();
        i_rstn = 1'b1;
        sample();
        check(name, 64'({o_fifo_rd, o_valid, o_data, o_sof, o_eol, o_eof, o_busy, o_starved}), 64'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            adv();
            sample();
        end
    endtask

    initial begin
        int  rds;
        int  gap;
        bit  seen;
        bit  prev_rd;
        int  rd_seen;
        bit  hit;

        i_rstn       = 1'b0;
        i_req        = 1'b0;
        i_fifo_empty = 1'b0;
        i_clr_status = 1'b0;
        for (int i = 0; i < MEMSZ; i++) mem[i] = i[DW-1:0];

        tbl[0]  = mk(1,0,0, 0,0,8'd0,  0,0,0, 0,0);
        tbl[1]  = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,0);
        tbl[2]  = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,0);
        tbl[3]  = mk(0,0,0, 1,1,8'd0,  1,0,0, 1,0);
        tbl[4]  = mk(0,0,0, 1,1,8'd1,  0,0,0, 1,0);
        tbl[5]  = mk(0,0,0, 1,1,8'd2,  0,0,0, 1,0);
        tbl[6]  = mk(0,0,0, 1,1,8'd3,  0,0,0, 1,0);
        tbl[7]  = mk(0,0,0, 1,1,8'd4,  0,0,0, 1,0);
        tbl[8]  = mk(0,0,0, 1,1,8'd5,  0,0,0, 1,0);
        tbl[9]  = mk(0,0,0, 0,1,8'd6,  0,0,0, 1,0);
        tbl[10] = mk(0,0,0, 0,1,8'd7,  0,1,0, 1,0);
        tbl[11] = mk(0,0,0, 0,0,8'd0,  0,0,0, 0,0);
        tbl[12] = mk(1,0,0, 0,0,8'd0,  0,0,0, 0,0);
        tbl[13] = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,0);
        tbl[14] = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,0);
        tbl[15] = mk(0,0,0, 1,1,8'd8,  0,0,0, 1,0);
        tbl[16] = mk(0,1,0, 0,1,8'd9,  0,0,0, 1,0);
        tbl[17] = mk(0,1,0, 0,1,8'd10, 0,0,0, 1,1);
        tbl[18] = mk(0,1,0, 0,0,8'd0,  0,0,0, 1,1);
        tbl[19] = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,1);
        tbl[20] = mk(0,0,0, 1,0,8'd0,  0,0,0, 1,1);
        tbl[21] = mk(0,0,0, 1,1,8'd11, 0,0,0, 1,1);
        tbl[22] = mk(0,0,0, 1,1,8'd12, 0,0,0, 1,1);
        tbl[23] = mk(0,0,0, 1,1,8'd13, 0,0,0, 1,1);
        tbl[24] = mk(0,0,0, 0,1,8'd14, 0,0,0, 1,1);
        tbl[25] = mk(0,0,0, 0,1,8'd15, 0,1,0, 1,1);
        tbl[26] = mk(0,0,1, 0,0,8'd0,  0,0,0, 0,1);
        tbl[27] = mk(0,0,0, 0,0,8'd0,  0,0,0, 0,0);

        do_reset("reset_state");

        // single-line request, then a line with a 3-cycle FIFO underrun and status clear
        for (int i = 0; i < 28; i++) begin
            adv();
            i_req        = tbl[i].req;
            i_fifo_empty = tbl[i].empty;
            i_clr_status = tbl[i].clr;
            sample();
            check($sformatf("table[%0d] ctl", i),
                  64'({o_fifo_rd, o_valid, o_sof, o_eol, o_eof, o_busy, o_starved}),
                  64'({tbl[i].rd, tbl[i].valid, tbl[i].sof, tbl[i].eol, tbl[i].eof,
                       tbl[i].busy, tbl[i].starved}));
            if (tbl[i].valid) check($sformatf("table[%0d] data", i), 64'(o_data), 64'(tbl[i].data));
        end
        i_clr_status = 1'b0;

        // req held for five lines: gaps of RG+1 idle read cycles, eof on pixel 31, sof wraps
        mon_en = 1'b1;
        do_reset("reset_before_hold");
        i_req   = 1'b1;
        rds     = 0;
        gap     = 0;
        seen    = 1'b0;
        prev_rd = 1'b0;
        for (int c = 0; c < 300 && rds < 4 * LL + 1; c++) begin
            adv();
            sample();
            if (o_fifo_rd) begin
                if (!prev_rd && seen) check("burst_gap", 64'(gap), 64'(RG + 1));
                gap  = 0;
                seen = 1'b1;
                rds++;
            end else begin
                gap++;
            end
            prev_rd = o_fifo_rd;
        end
        adv();
        i_req = 1'b0;
        sample();
        rds += int'(o_fifo_rd);
        for (int c = 0; c < 30; c++) begin
            adv();
            sample();
            rds += int'(o_fifo_rd);
        end
        check("hold_reads", 64'(rds), 64'(5 * LL));
        check("hold_valids", 64'(mon_n), 64'(5 * LL));
        check("hold_sof_count", 64'(sof_cnt), 64'(2));
        check("hold_eof_count", 64'(eof_cnt), 64'(1));

        // req dropped after second pixel: the line still completes, no new burst
        do_reset("reset_before_drop");
        adv();
        i_req = 1'b1;
        sample();
        rds = int'(o_fifo_rd);
        for (int c = 0; c < 40; c++) begin
            adv();
            if (rds >= 2) i_req = 1'b0;
            sample();
            rds += int'(o_fifo_rd);
        end
        check("drop_reads", 64'(rds), 64'(LL));
        check("drop_valids", 64'(mon_n), 64'(LL));
        check("drop_busy", 64'(o_busy), 64'(0));

        // reset at pixel 4 of line 2: outputs cleared, next line starts fresh with sof
        do_reset("reset_before_midline");
        i_req = 1'b1;
        hit   = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            adv();
            sample();
            hit = (mon_n == 2 * LL + 4);
        end
        check("midline_reached", 64'(hit), 64'(1));
        do_reset("midline_reset_outputs");
        adv();
        i_req = 1'b1;
        sample();
        adv();
        i_req = 1'b0;
        sample();
        idle_cycles(30);
        check("after_reset_valids", 64'(mon_n), 64'(LL));
        check("after_reset_sof", 64'(sof_cnt), 64'(1));

        // clear and starvation in the same cycle: clear wins
        do_reset("reset_before_clr");
        adv();
        i_req = 1'b1;
        sample();
        adv();
        i_req        = 1'b0;
        i_fifo_empty = 1'b1;
        i_clr_status = 1'b1;
        sample();
        adv();
        i_clr_status = 1'b0;
        sample();
        check("clr_wins", 64'(o_starved), 64'(0));
        adv();
        i_fifo_empty = 1'b0;
        sample();
        check("starve_sets", 64'(o_starved), 64'(1));
        idle_cycles(20);
        check("starve_sticky", 64'(o_starved), 64'(1));
        check("starve_line_valids", 64'(mon_n), 64'(LL));

        // randomized traffic against the stream reference
        for (int k = 0; k < 1200; k++) mem[(rd_ptr + k) % MEMSZ] = DW'($urandom);
        do_reset("reset_before_random");
        rd_seen = 0;
        for (int c = 0; c < 800; c++) begin
            adv();
            i_req        = ($urandom_range(0, 2) == 0);
            i_fifo_empty = ($urandom_range(0, 3) == 0);
            i_clr_status = ($urandom_range(0, 15) == 0);
            sample();
            if (o_fifo_rd) check("rd_while_empty", 64'(i_fifo_empty), 64'(0));
            rd_seen += int'(o_fifo_rd);
        end
        adv();
        i_req        = 1'b0;
        i_fifo_empty = 1'b0;
        i_clr_status = 1'b0;
        sample();
        rd_seen += int'(o_fifo_rd);
        for (int c = 0; c < 40; c++) begin
            adv();
            sample();
            rd_seen += int'(o_fifo_rd);
        end
        check("random_drain_busy", 64'(o_busy), 64'(0));
        check("random_reads_vs_valids", 64'(rd_seen), 64'(mon_n));
        check("random_whole_lines", 64'(mon_n % LL), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
